// File: rtl/stream_demux4_pkg.sv
// Shared constants, entry layout and the one-hot helper for the 4-way stream demux.
package stream_demux4_pkg;

  localparam int NPORTS       = 4;
  localparam int SEL_W        = 2;
  localparam int DEFAULT_XLEN = 32;

  // Reference layout at the default payload width; the top rebuilds it at its own XLEN.
  typedef struct packed {
    logic [SEL_W-1:0]        sel;
    logic [DEFAULT_XLEN-1:0] data;
  } demux_entry_t;

  function automatic logic [NPORTS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NPORTS-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry in-order FIFO with registered occupancy; flush wins over push and pop.
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   level
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_level;
  logic         w_push;
  logic         w_pop;

  assign w_push = push && (r_level != 2'd2) && !flush;
  assign w_pop  = pop  && (r_level != 2'd0) && !flush;

  // Storage is never visible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_level <= 2'd0;
    end else if (flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_level <= 2'd0;
    end else begin
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 2'd1;
        2'b01:   r_level <= r_level - 2'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];
  assign level = r_level;

endmodule

// File: rtl/stream_demux4.sv
// One input stream routed to one of four outputs by a per-entry select, buffered two deep.
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic [XLEN-1:0]   s_data,
  output logic [NPORTS-1:0] m_valid,
  input  logic [NPORTS-1:0] m_ready,
  output logic [XLEN-1:0]   m_data,
  output logic [1:0]        level
);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  data;
  } entry_t;

  entry_t     w_wr;
  entry_t     w_head;
  logic [1:0] w_level;
  logic       w_have;
  logic       w_push;
  logic       w_pop;

  assign w_wr.sel  = s_sel;
  assign w_wr.data = s_data;

  // s_ready depends only on registered level, so m_ready never reaches it combinationally.
  assign s_ready = rst_n && (w_level != 2'd2) && !flush;
  assign w_push  = s_valid && s_ready;
  assign w_have  = (w_level != 2'd0);
  assign w_pop   = w_have && m_ready[w_head.sel];

  skid_fifo2 #(
    .W($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (w_push),
    .wdata (w_wr),
    .pop   (w_pop),
    .rdata (w_head),
    .level (w_level)
  );

  assign m_valid = w_have ? sel_onehot(w_head.sel) : '0;
  assign m_data  = w_have ? w_head.data : '0;
  assign level   = w_level;

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning payload width in bits.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The module SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-005 The module SHALL have port s_valid, input, 1, upstream entry offered.
REQ-006 The module SHALL have port s_ready, output, 1, upstream entry can be accepted.
REQ-007 The module SHALL have port s_sel, input, 2, destination port index 0..3.
REQ-008 The module SHALL have port s_data, input, XLEN, upstream payload.
REQ-009 The module SHALL have port m_valid, output, 4, one-hot downstream valid, bit i for port i.
REQ-010 The module SHALL have port m_ready, input, 4, per-port downstream ready.
REQ-011 The module SHALL have port m_data, output, XLEN, payload shared by all four ports.
REQ-012 The module SHALL have port level, output, 2, buffer occupancy 0..2.

Function
REQ-013 The module SHALL hold a 2-entry in-order FIFO of {sel, data} entries.
REQ-014 Push SHALL occur when s_valid && s_ready; pop SHALL occur when m_valid[head.sel] && m_ready[head.sel].
REQ-015 s_ready SHALL equal (level != 2) && !flush; with registered level there is no combinational path from m_ready to s_ready.
REQ-016 When level > 0, m_valid SHALL be one-hot at bit head.sel and m_data SHALL equal head.data; when level == 0, m_valid SHALL be 4'b0000 and m_data SHALL be 0.
REQ-017 Latency: an entry pushed at edge N into an empty buffer SHALL be visible on m_valid/m_data in the cycle after edge N; there is no same-cycle bypass.
REQ-018 Entries SHALL leave in acceptance order; a stalled head SHALL block later entries to other ports (head-of-line blocking).
REQ-019 m_ready bits other than head.sel SHALL have no effect.
REQ-020 Push and pop in the same cycle at level 1 SHALL leave level at 1, with the new entry becoming head after the pop.
REQ-021 At level 2, s_ready SHALL be 0, so a push cannot coincide with a full buffer; a pop at level 2 SHALL give level 1 and raise s_ready in the next cycle.
REQ-022 m_valid and m_data SHALL stay stable while the head is not popped.
REQ-023 flush SHALL take priority over push and pop: level becomes 0 at the edge and any handshake presented in that cycle is discarded.
REQ-024 Read and write pointers SHALL be 1 bit each and wrap 1->0; level SHALL never exceed 2 or underflow below 0.

Reset
REQ-025 On rst_n low, asynchronously: level=0, pointers=0, m_valid=4'b0000, m_data=0, s_ready=0 while rst_n is low.
REQ-026 Storage contents SHALL NOT be reset; they are never observable when level==0.
REQ-027 Reset asserted mid-transfer SHALL drop all buffered entries; after rst_n rises, s_ready=1 in the first cycle.

Structure
REQ-028 A shared package SHALL define NPORTS=4, SEL_W=2 and the typedef demux_entry_t {sel[SEL_W-1:0], data[XLEN-1:0]}; XLEN stays a module parameter.
REQ-029 The 2-entry FIFO SHALL be a sub-module named skid_fifo2, parameterised on entry width; stream_demux4 adds only the one-hot decode and the pop select.

Verification
REQ-030 Reset then push {sel=2, data=0xDEADBEEF}: next cycle m_valid=4'b0100, m_data=0xDEADBEEF, level=1; with m_ready=4'b0100 it pops and level=0.
REQ-031 Push sel=1 and sel=3 back-to-back with m_ready=0: level=2, s_ready=0, m_valid=4'b0010 held; m_ready=4'b1000 causes no pop.
REQ-032 Stream 8 entries, sel 0,1,2,3,0,1,2,3, data 1..8, all m_ready=1: one accepted per cycle, order preserved, s_ready never drops.
REQ-033 Level 2, assert flush with s_valid=1 and m_ready=4'hF: next cycle level=0, m_valid=0, no transfer counted.
REQ-034 Level 1, push and pop same cycle: level stays 1, new head data visible, old data gone.
REQ-035 Drop rst_n asynchronously between edges at level 2: outputs go to reset values immediately; on release, s_ready=1 and level=0.
